// File: rtl/neuron_mac_sequencer.sv
// Neuron MAC sequencer: reads N (x,w) pairs, accumulates, scales, saturates, writes back.
// Define NEURON_RELU_EN to clamp negative activations to zero.
`timescale 1ns/1ps
module neuron_mac_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 7,
  parameter int ACC_W  = 20,
  parameter int SHIFT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              sat,
  output logic [ADDR_W-1:0] read_address,
  output logic              oe,
  input  logic [DATA_W-1:0] read_data,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              wre
);

  typedef enum logic [1:0] {
    IDLE,
    RD_X,
    RD_W,
    WRITE
  } state_t;

  localparam int PW = 2 * DATA_W;
  localparam logic [CNT_W-1:0] CNT_ONE =
    {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W-1:0] HI =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] LO = ~HI;

  state_t state, state_nx;

  logic [ADDR_W-1:0]        base_q;
  logic [ADDR_W-1:0]        out_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [CNT_W-1:0]         idx_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] x_q;

  logic [ADDR_W-1:0]        pair_addr;
  logic signed [DATA_W-1:0] rd_s;
  logic signed [PW-1:0]     prod;
  logic signed [ACC_W-1:0]  acc_nx;
  logic signed [ACC_W-1:0]  sh;
  logic [DATA_W-1:0]        f_val;
  logic                     f_sat;
  logic                     last_pair;

  assign pair_addr = base_q + ADDR_W'({idx_q, 1'b0});
  assign rd_s      = $signed(read_data);
  assign prod      = x_q * rd_s;
  assign acc_nx    = acc_q +
    {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign sh        = acc_q >>> SHIFT;
  assign last_pair = (idx_q == (cnt_q - CNT_ONE));

  // Activation: scaled accumulator clipped to the DATA_W range
  always_comb begin
    f_val = sh[DATA_W-1:0];
    f_sat = 1'b0;
`ifdef NEURON_RELU_EN
    if (sh[ACC_W-1]) begin
      f_val = '0;
    end else if (sh > HI) begin
      f_val = HI[DATA_W-1:0];
      f_sat = 1'b1;
    end
`else
    if (sh > HI) begin
      f_val = HI[DATA_W-1:0];
      f_sat = 1'b1;
    end else if (sh < LO) begin
      f_val = LO[DATA_W-1:0];
      f_sat = 1'b1;
    end
`endif
  end

  always_comb begin
    state_nx      = state;
    oe            = 1'b0;
    wre           = 1'b0;
    read_address  = '0;
    write_address = '0;
    write_data    = '0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = (count == '0) ? WRITE : RD_X;
      end
      RD_X: begin
        oe           = 1'b1;
        read_address = pair_addr;
        state_nx     = RD_W;
      end
      RD_W: begin
        oe           = 1'b1;
        read_address = pair_addr + ADDR_W'(1);
        state_nx     = last_pair ? WRITE : RD_X;
      end
      WRITE: begin
        wre           = 1'b1;
        write_address = out_q;
        write_data    = f_val;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      base_q <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      acc_q  <= '0;
      x_q    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      sat    <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            cnt_q  <= count;
            out_q  <= out_addr;
            acc_q  <= '0;
            idx_q  <= '0;
            busy   <= 1'b1;
          end
        end
        RD_X: x_q <= rd_s;
        RD_W: begin
          acc_q <= acc_nx;
          idx_q <= idx_q + CNT_ONE;
        end
        WRITE: begin
          result <= f_val;
          sat    <= f_sat;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench for neuron_mac_sequencer with a behavioural dual-port RAM.
// Expected values follow NEURON_RELU_EN when it is defined.
`timescale 1ns/1ps
module tb_neuron_mac_sequencer;

`ifdef NEURON_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] base_addr;
  logic [6:0] count;
  logic [7:0] out_addr;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       sat;
  logic [7:0] read_address;
  logic       oe;
  logic [7:0] read_data;
  logic [7:0] write_address;
  logic [7:0] write_data;
  logic       wre;

  logic [7:0] ram [0:255];
  logic [7:0] addr_log [0:31];
  int n_log;
  int errors = 0;
  int checks = 0;
  int wre_total = 0;

  neuron_mac_sequencer dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_addr(base_addr),
    .count(count),
    .out_addr(out_addr),
    .busy(busy),
    .done(done),
    .result(result),
    .sat(sat),
    .read_address(read_address),
    .oe(oe),
    .read_data(read_data),
    .write_address(write_address),
    .write_data(write_data),
    .wre(wre)
  );

  always #5 clk = ~clk;

  assign read_data = oe ? ram[read_address] : 8'h00;

  always @(posedge clk) begin
    if (wre) begin
      ram[write_address] = write_data;
      wre_total = wre_total + 1;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic run(input logic [7:0] b,
                     input logic [6:0] n,
                     input logic [7:0] o,
                     input bit hold,
                     output int lat,
                     output int n_oe,
                     output int n_wre);
    base_addr = b;
    count     = n;
    out_addr  = o;
    start     = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    lat   = -1;
    n_oe  = 0;
    n_wre = 0;
    n_log = 0;
    for (int k = 1; k <= 300; k++) begin
      if (oe) begin
        n_oe++;
        if (n_log < 32) addr_log[n_log] = read_address;
        n_log++;
      end
      if (wre) n_wre++;
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  int lat, n_oe, n_wre, w0;
  logic [7:0] exp_v;
  logic       exp_s;

  initial begin
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    count = '0;
    out_addr = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_oe", oe, 0);
    check("rst_wre", wre, 0);
    check("rst_result", result, 0);
    check("rst_sat", sat, 0);
    check("rst_raddr", read_address, 0);
    check("rst_waddr", write_address, 0);
    check("rst_wdata", write_data, 0);
    rst = 1'b0;

    // basic pair: 10*10 + 11*11 = 221 -> 13
    ram[0] = 8'd10; ram[1] = 8'd10;
    ram[2] = 8'd11; ram[3] = 8'd11;
    run(8'd0, 7'd2, 8'd8, 1'b0, lat, n_oe, n_wre);
    check("t1_lat", lat, 5);
    check("t1_oe", n_oe, 4);
    check("t1_wre", n_wre, 1);
    check("t1_ram", ram[8], 8'd13);
    check("t1_result", result, 8'd13);
    check("t1_sat", sat, 0);
    check("t1_busy", busy, 0);

    // back-to-back, positive saturation
    for (int i = 16; i < 24; i++) ram[i] = 8'd127;
    run(8'd16, 7'd4, 8'd40, 1'b0, lat, n_oe, n_wre);
    check("t2_lat", lat, 9);
    check("t2_ram", ram[40], 8'd127);
    check("t2_result", result, 8'd127);
    check("t2_sat", sat, 1);
    @(posedge clk); #1;
    check("t2_done_pulse", done, 0);
    check("t2_busy", busy, 0);

    // -10*20 = -200 -> -13
    ram[50] = 8'hF6; ram[51] = 8'd20;
    run(8'd50, 7'd1, 8'd52, 1'b0, lat, n_oe, n_wre);
    exp_v = RELU ? 8'h00 : 8'hF3;
    check("t3_lat", lat, 3);
    check("t3_ram", ram[52], exp_v);
    check("t3_sat", sat, 0);

    // negative saturation: 2*(127*-128) = -32512 -> -2032
    ram[60] = 8'd127; ram[61] = 8'h80;
    ram[62] = 8'd127; ram[63] = 8'h80;
    run(8'd60, 7'd2, 8'd64, 1'b0, lat, n_oe, n_wre);
    exp_v = RELU ? 8'h00 : 8'h80;
    exp_s = RELU ? 1'b0 : 1'b1;
    check("t4_ram", ram[64], exp_v);
    check("t4_sat", sat, exp_s);

    // exactly +127 after shift: not clipped
    ram[70] = 8'd127; ram[71] = 8'd16;
    run(8'd70, 7'd1, 8'd72, 1'b0, lat, n_oe, n_wre);
    check("t5_ram", ram[72], 8'h7F);
    check("t5_sat", sat, 0);

    // exactly -128 after shift: not clipped
    ram[74] = 8'h80; ram[75] = 8'd16;
    run(8'd74, 7'd1, 8'd76, 1'b0, lat, n_oe, n_wre);
    exp_v = RELU ? 8'h00 : 8'h80;
    check("t6_ram", ram[76], exp_v);
    check("t6_sat", sat, 0);

    // N=0 with start held into the busy cycle
    @(posedge clk); #1;
    ram[90] = 8'h55;
    w0 = wre_total;
    run(8'd0, 7'd0, 8'd90, 1'b1, lat, n_oe, n_wre);
    check("t7_lat", lat, 1);
    check("t7_oe", n_oe, 0);
    check("t7_ram", ram[90], 8'h00);
    check("t7_result", result, 8'h00);
    repeat (4) @(posedge clk);
    #1;
    check("t7_wre_once", wre_total - w0, 1);
    check("t7_busy", busy, 0);

    // address wrap: FE, FF, 00, 01
    ram[8'hFE] = 8'd2; ram[8'hFF] = 8'd3;
    ram[0] = 8'd4; ram[1] = 8'd5;
    run(8'hFE, 7'd2, 8'd100, 1'b0, lat, n_oe, n_wre);
    check("t8_a0", addr_log[0], 8'hFE);
    check("t8_a1", addr_log[1], 8'hFF);
    check("t8_a2", addr_log[2], 8'h00);
    check("t8_a3", addr_log[3], 8'h01);
    check("t8_wre", n_wre, 1);
    check("t8_ram", ram[100], 8'd1);

    // reset in the middle of an N=2 run
    @(posedge clk); #1;
    ram[120] = 8'hAA;
    for (int i = 110; i < 114; i++) ram[i] = 8'd1;
    w0 = wre_total;
    base_addr = 8'd110;
    count = 7'd2;
    out_addr = 8'd120;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t9_busy_pre", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t9_busy", busy, 0);
    check("t9_done", done, 0);
    check("t9_wre", wre, 0);
    repeat (8) @(posedge clk);
    #1;
    check("t9_no_write", wre_total - w0, 0);
    check("t9_ram", ram[120], 8'hAA);
    check("t9_done_late", done, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
